// File: rtl/conversor_bcd_bin.sv
// rtl/conversor_bcd_bin.sv - two-digit packed BCD to 7-bit binary, reverse double-dabble, optional CONVERSOR_CHECK_BCD_EN digit check
module conversor_bcd_bin (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bcd,
  output logic [6:0] bin,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  sr_bcd_q, sr_bcd_d;
  logic [6:0]  sr_bin_q, sr_bin_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  bin_q, bin_d;

  logic [14:0] shifted;
  logic [3:0]  sh_tens, sh_units;
  logic [3:0]  fix_tens, fix_units;
  logic [6:0]  sh_bin;
  logic        bad_path;

`ifdef CONVERSOR_CHECK_BCD_EN
  logic        err_q, err_d;
  logic        bad_q, bad_d;

  assign bad_path = bad_q;
  assign err      = err_q;
`else
  assign bad_path = 1'b0;
  assign err      = 1'b0;
`endif

  // One reverse double-dabble step: shift the pair right, then correct each digit
  always_comb begin
    shifted   = {1'b0, sr_bcd_q, sr_bin_q[6:1]};
    sh_tens   = shifted[14:11];
    sh_units  = shifted[10:7];
    sh_bin    = shifted[6:0];
    fix_tens  = (sh_tens  >= 4'd8) ? (sh_tens  - 4'd3) : sh_tens;
    fix_units = (sh_units >= 4'd8) ? (sh_units - 4'd3) : sh_units;
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    sr_bcd_d = sr_bcd_q;
    sr_bin_d = sr_bin_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
`ifdef CONVERSOR_CHECK_BCD_EN
    err_d    = err_q;
    bad_d    = bad_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_bcd_d = bcd;
          sr_bin_d = 7'd0;
          cnt_d    = 3'd0;
          state_d  = SHIFT;
`ifdef CONVERSOR_CHECK_BCD_EN
          err_d    = 1'b0;
          bad_d    = (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);
`endif
        end
      end
      SHIFT: begin
        if (bad_path) begin
          // Invalid operand: report immediately with a zero result
          bin_d   = 7'd0;
          state_d = DONE;
`ifdef CONVERSOR_CHECK_BCD_EN
          err_d   = 1'b1;
          bad_d   = 1'b0;
`endif
        end else begin
          sr_bcd_d = {fix_tens, fix_units};
          sr_bin_d = sh_bin;
          cnt_d    = cnt_q + 3'd1;
          if (cnt_q == 3'd6) begin
            bin_d   = sh_bin;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sr_bcd_q <= 8'd0;
      sr_bin_q <= 7'd0;
      cnt_q    <= 3'd0;
      bin_q    <= 7'd0;
`ifdef CONVERSOR_CHECK_BCD_EN
      err_q    <= 1'b0;
      bad_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sr_bcd_q <= sr_bcd_d;
      sr_bin_q <= sr_bin_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
`ifdef CONVERSOR_CHECK_BCD_EN
      err_q    <= err_d;
      bad_q    <= bad_d;
`endif
    end
  end

  assign bin  = bin_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_conversor_bcd_bin.sv
// tb/tb_conversor_bcd_bin.sv - self-checking bench for conversor_bcd_bin
module tb_conversor_bcd_bin;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] bcd;
  logic [6:0] bin;
  logic       busy;
  logic       done;
  logic       err;

  int n_vec;
  int n_miss;

  conversor_bcd_bin dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bcd   (bcd),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_bin(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_conv(input logic [7:0] b);
    int exp;
    exp = ref_bin(b);
    @(negedge clk);
    start = 1'b1;
    bcd   = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bcd   = 8'($urandom);
    chk("busy_k", int'(busy), 1);
    chk("done_k", int'(done), 0);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk("busy_run", int'(busy), 1);
      if (i < 7) begin
        chk("done_early", int'(done), 0);
      end else begin
        chk("done_k7", int'(done), 1);
        chk("bin", int'(bin), exp);
        chk("err_valid", int'(err), 0);
      end
    end
    @(negedge clk);
    chk("done_k8", int'(done), 0);
    chk("busy_k8", int'(busy), 0);
    chk("bin_hold", int'(bin), exp);
  endtask

  task automatic wait_done(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    chk(tag, int'(found), 1);
  endtask

`ifdef CONVERSOR_CHECK_BCD_EN
  task automatic run_bad(input logic [7:0] b);
    @(negedge clk);
    start = 1'b1;
    bcd   = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("bad_busy_k", int'(busy), 1);
    chk("bad_done_k", int'(done), 0);
    @(negedge clk);
    chk("bad_done_k1", int'(done), 1);
    chk("bad_err", int'(err), 1);
    chk("bad_bin", int'(bin), 0);
    chk("bad_busy_k1", int'(busy), 1);
    @(negedge clk);
    chk("bad_done_k2", int'(done), 0);
    chk("bad_busy_k2", int'(busy), 0);
    chk("bad_err_hold", int'(err), 1);
  endtask
`endif

  initial begin
    logic [7:0] rb;
    logic       saw_done;
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    start  = 1'b0;
    bcd    = 8'd0;

    // Reset state
    #12;
    chk("rst_bin", int'(bin), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed operands
    run_conv(8'h11);
    run_conv(8'h99);
    run_conv(8'h00);
    run_conv(8'h02);

    // Randomized valid operands
    for (int n = 0; n < 20; n++) begin
      rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      run_conv(rb);
    end

    // start held high; bcd change mid-conversion applies to the next accept
    @(negedge clk);
    start = 1'b1;
    bcd   = 8'h42;
    wait_done("held_done1");
    chk("held_bin1", int'(bin), 42);
    @(negedge clk);
    chk("held_pulse1", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    bcd = 8'h17;
    wait_done("held_done2");
    chk("held_bin2", int'(bin), 42);
    @(negedge clk);
    chk("held_pulse2", int'(done), 0);
    wait_done("held_done3");
    chk("held_bin3", int'(bin), 17);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("held_idle", int'(busy), 0);

    // Reset mid-conversion
    @(negedge clk);
    start = 1'b1;
    bcd   = 8'h64;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_bin", int'(bin), 0);
    chk("abort_err", int'(err), 0);
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", int'(saw_done), 0);
    run_conv(8'h64);

`ifdef CONVERSOR_CHECK_BCD_EN
    run_bad(8'hA5);
    run_conv(8'h37);
    for (int n = 0; n < 6; n++) begin
      if (n[0]) rb = {4'($urandom_range(10, 15)), 4'($urandom_range(0, 15))};
      else      rb = {4'($urandom_range(0, 9)), 4'($urandom_range(10, 15))};
      run_bad(rb);
      run_conv({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
